// File: rtl/teclado_pkg.sv
// teclado_pkg: shared types and constants for the 4x4 keypad peripheral.
//   estado_t      scan FSM states
//   KEY_MAP       hex code for each key, indexed by {row, col}
//   NEW_KEY_BIT   bit position of new_key in the read word
//   OVERRUN_BIT   bit position of overrun in the read word
//   ROWS_IDLE     synchronized row pattern with no key pulling low
//   is_single()   true when exactly one row is low
//   low_row()     index of the low row (meaningful only when is_single)
package teclado_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2
    } estado_t;

    // Row-major: row0 "1 2 3 A", row1 "4 5 6 B", row2 "7 8 9 C", row3 "* 0 # D"
    // with '*' reported as E and '#' as F.
    localparam logic [3:0] KEY_MAP [0:15] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'hE, 4'h0, 4'hF, 4'hD
    };

    localparam int NEW_KEY_BIT = 15;
    localparam int OVERRUN_BIT = 14;

    localparam logic [3:0] ROWS_IDLE = 4'hF;

    function automatic logic is_single(input logic [3:0] rows);
        return (rows == 4'b1110) || (rows == 4'b1101) ||
               (rows == 4'b1011) || (rows == 4'b0111);
    endfunction

    function automatic logic [1:0] low_row(input logic [3:0] rows);
        logic [1:0] idx;
        idx = 2'd0;
        case (rows)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/divisor_tick.sv
// divisor_tick: free-running prescaler, counts 0..CLK_DIV-1 and pulses
// tick_o for one cycle while the count sits at CLK_DIV-1.
//   clk_i   system clock
//   rst_i   synchronous active-low reset (count back to 0)
//   tick_o  one-cycle scan tick
module divisor_tick #(
    parameter int CLK_DIV = 1000
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic tick_o
);

    localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick_o = (cnt == LAST);

endmodule

// File: rtl/peri_teclado_4x4.sv
// peri_teclado_4x4: memory-mapped 4x4 keypad scanner with debounce and a
// read-to-clear status word.
//   clk_i         system clock
//   rst_i         synchronous active-low reset
//   rd_teclado_i  one-cycle read strobe, consumes the pending key
//   row_i         keypad rows, active-low, asynchronous
//   col_o         keypad column drive, active-low one-hot
//   d_o           {new_key, overrun, 10'b0, key_code}
//   key_valid_o   high while an accepted key is held
//
// state    | meaning
// SCAN     | rotating columns, waiting for a single low row
// DEBOUNCE | column held, counting identical single-row ticks
// PRESSED  | key accepted, counting idle ticks for release
module peri_teclado_4x4
    import teclado_pkg::*;
#(
    parameter int CLK_DIV   = 1000,
    parameter int DEB_COUNT = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        rd_teclado_i,
    input  logic [3:0]  row_i,
    output logic [3:0]  col_o,
    output logic [15:0] d_o,
    output logic        key_valid_o
);

    localparam logic [3:0] DEB_LIM = 4'(DEB_COUNT);

    logic       tick;
    logic [3:0] rows_m;
    logic [3:0] rows_s;

    estado_t    state, state_n;
    logic [1:0] col, col_n;
    logic [1:0] row_idx, row_n;
    logic [3:0] deb_cnt, deb_n;
    logic [3:0] rel_cnt, rel_n;
    logic       accept;

    logic       new_key;
    logic       overrun;
    logic [3:0] key_code;

    logic       single;
    logic [1:0] row_now;

    divisor_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_divisor_tick (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .tick_o (tick)
    );

    // Two-flop synchronizer; resets to the idle (all-high) pattern.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            rows_m <= ROWS_IDLE;
            rows_s <= ROWS_IDLE;
        end else begin
            rows_m <= row_i;
            rows_s <= rows_m;
        end
    end

    assign single  = is_single(rows_s);
    assign row_now = low_row(rows_s);

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state   <= SCAN;
            col     <= 2'd0;
            row_idx <= 2'd0;
            deb_cnt <= 4'd0;
            rel_cnt <= 4'd0;
        end else begin
            state   <= state_n;
            col     <= col_n;
            row_idx <= row_n;
            deb_cnt <= deb_n;
            rel_cnt <= rel_n;
        end
    end

    always_comb begin
        state_n = state;
        col_n   = col;
        row_n   = row_idx;
        deb_n   = deb_cnt;
        rel_n   = rel_cnt;
        accept  = 1'b0;
        if (tick) begin
            case (state)
                SCAN: begin
                    if (single) begin
                        row_n   = row_now;
                        deb_n   = 4'd1;
                        state_n = DEBOUNCE;
                    end else begin
                        col_n = col + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (single && (row_now == row_idx)) begin
                        deb_n = deb_cnt + 4'd1;
                        if (deb_n == DEB_LIM) begin
                            accept  = 1'b1;
                            deb_n   = 4'd0;
                            rel_n   = 4'd0;
                            state_n = PRESSED;
                        end
                    end else begin
                        col_n   = col + 2'd1;
                        deb_n   = 4'd0;
                        state_n = SCAN;
                    end
                end
                PRESSED: begin
                    // Any non-idle pattern (including ghosts or roll-over)
                    // only restarts the release count.
                    if (rows_s == ROWS_IDLE) begin
                        rel_n = rel_cnt + 4'd1;
                        if (rel_n == DEB_LIM) begin
                            rel_n   = 4'd0;
                            col_n   = col + 2'd1;
                            state_n = SCAN;
                        end
                    end else begin
                        rel_n = 4'd0;
                    end
                end
                default: begin
                    state_n = SCAN;
                end
            endcase
        end
    end

    // Accept has priority over a same-cycle read: the read consumed the old
    // key, so the new one is pending and nothing was lost.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            new_key  <= 1'b0;
            overrun  <= 1'b0;
            key_code <= 4'h0;
        end else if (accept) begin
            key_code <= KEY_MAP[{row_idx, col}];
            new_key  <= 1'b1;
            overrun  <= new_key & ~rd_teclado_i;
        end else if (rd_teclado_i && new_key) begin
            new_key <= 1'b0;
            overrun <= 1'b0;
        end
    end

    always_comb begin
        d_o              = 16'h0000;
        d_o[NEW_KEY_BIT] = new_key;
        d_o[OVERRUN_BIT] = overrun;
        d_o[3:0]         = key_code;
    end

    assign col_o       = ~(4'b0001 << col);
    assign key_valid_o = (state == PRESSED);

endmodule

// File: tb/tb_peri_teclado_4x4.sv
// tb_peri_teclado_4x4: directed bench for the keypad peripheral with a
// behavioural keypad (held[] matrix shorting rows to driven columns).
module tb_peri_teclado_4x4;

    logic        clk_i;
    logic        rst_i;
    logic        rd_teclado_i;
    logic [3:0]  row_i;
    logic [3:0]  col_o;
    logic [15:0] d_o;
    logic        key_valid_o;

    logic [15:0] held;
    int          checks;
    int          errors;

    peri_teclado_4x4 #(
        .CLK_DIV   (10),
        .DEB_COUNT (4)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .rd_teclado_i (rd_teclado_i),
        .row_i        (row_i),
        .col_o        (col_o),
        .d_o          (d_o),
        .key_valid_o  (key_valid_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Keypad: a held key at (r,c) pulls row r low while column c is driven.
    always_comb begin
        row_i = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (held[r*4+c] && !col_o[c]) row_i[r] = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic wait_col(input logic [3:0] v, input string tag);
        int n;
        n = 0;
        while (col_o !== v && n < 400) begin
            step();
            n++;
        end
        check(tag, 32'(col_o), 32'(v));
    endtask

    task automatic wait_col_change(input string tag);
        logic [3:0] c;
        int n;
        c = col_o;
        n = 0;
        while (col_o === c && n < 400) begin
            step();
            n++;
        end
        check(tag, 32'(col_o !== c), 32'd1);
    endtask

    task automatic wait_valid(input logic v, input string tag);
        int n;
        n = 0;
        while (key_valid_o !== v && n < 400) begin
            step();
            n++;
        end
        check(tag, 32'(key_valid_o), 32'(v));
    endtask

    task automatic do_read(input logic [15:0] pre, input logic [15:0] post, input string tag);
        rd_teclado_i = 1'b1;
        check({tag, "_pre"}, 32'(d_o), 32'(pre));
        step();
        rd_teclado_i = 1'b0;
        check({tag, "_post"}, 32'(d_o), 32'(post));
    endtask

    task automatic check_rotation_after_reset(input string tag);
        repeat (9) step();
        check({tag, "_col_9"}, 32'(col_o), 32'h0000_000E);
        step();
        check({tag, "_col_10"}, 32'(col_o), 32'h0000_000D);
    endtask

    initial begin
        int n;
        int changes;
        logic [3:0] c0;
        logic [3:0] prev;

        checks       = 0;
        errors       = 0;
        held         = 16'h0000;
        rd_teclado_i = 1'b0;
        rst_i        = 1'b0;

        // Reset state and first column rotation
        repeat (3) step();
        check("rst_col", 32'(col_o), 32'h0000_000E);
        check("rst_d", 32'(d_o), 32'h0000_0000);
        check("rst_valid", 32'(key_valid_o), 32'd0);
        rst_i = 1'b1;
        check_rotation_after_reset("rot");
        step();
        check("rot_col_hold", 32'(col_o), 32'h0000_000D);
        repeat (9) step();
        check("rot_col_20", 32'(col_o), 32'h0000_000B);

        // Key '5' held: accept exactly 40 cycles after col1 is first driven
        held[5] = 1'b1;
        wait_col(4'b1101, "k5_wait_col1");
        n = 0;
        while (key_valid_o !== 1'b1 && n < 400) begin
            step();
            n++;
        end
        check("k5_latency", 32'(n), 32'd40);
        check("k5_d", 32'(d_o), 32'h0000_8005);
        check("k5_col_held", 32'(col_o), 32'h0000_000D);
        do_read(16'h8005, 16'h0005, "k5_rd");
        check("k5_valid_after_rd", 32'(key_valid_o), 32'd1);
        held = 16'h0000;
        wait_valid(1'b0, "k5_release");
        check("k5_d_after_rel", 32'(d_o), 32'h0000_0005);

        // Bouncing '5' on alternate ticks, then stable
        wait_col_change("bnc_align");
        for (int k = 1; k <= 6; k++) begin
            held[5] = (k % 2 == 1);
            repeat (10) step();
            check("bnc_no_valid", 32'(key_valid_o), 32'd0);
            check("bnc_no_new", 32'(d_o), 32'h0000_0005);
        end
        held[5] = 1'b1;
        wait_valid(1'b1, "bnc_accept");
        check("bnc_d", 32'(d_o), 32'h0000_8005);
        repeat (60) step();
        check("bnc_single_accept", 32'(d_o), 32'h0000_8005);
        do_read(16'h8005, 16'h0005, "bnc_rd");
        held = 16'h0000;
        wait_valid(1'b0, "bnc_release");

        // Two keys without a read: overrun
        held[0] = 1'b1;
        wait_valid(1'b1, "ov_k1_press");
        check("ov_k1_d", 32'(d_o), 32'h0000_8001);
        held = 16'h0000;
        wait_valid(1'b0, "ov_k1_release");
        held[14] = 1'b1;
        wait_valid(1'b1, "ov_hash_press");
        held = 16'h0000;
        wait_valid(1'b0, "ov_hash_release");
        check("ov_d", 32'(d_o), 32'h0000_C00F);
        do_read(16'hC00F, 16'h000F, "ov_rd");
        step();
        rd_teclado_i = 1'b1;
        step();
        rd_teclado_i = 1'b0;
        check("rd_idle_no_effect", 32'(d_o), 32'h0000_000F);

        // Rows 0 and 2 low together on col2: not single, keeps rotating
        held[2]  = 1'b1;
        held[10] = 1'b1;
        wait_col_change("ghost_align");
        c0      = col_o;
        prev    = col_o;
        changes = 0;
        for (int i = 0; i < 80; i++) begin
            step();
            if (col_o !== prev) begin
                changes++;
                prev = col_o;
            end
        end
        check("ghost_changes", 32'(changes), 32'd8);
        check("ghost_col_back", 32'(col_o), 32'(c0));
        check("ghost_valid", 32'(key_valid_o), 32'd0);
        check("ghost_d", 32'(d_o), 32'h0000_000F);
        held = 16'h0000;

        // Read in the exact accept cycle of 'A' while new_key is set
        held[1] = 1'b1;
        wait_valid(1'b1, "col_k2_press");
        check("col_k2_d", 32'(d_o), 32'h0000_8002);
        held = 16'h0000;
        wait_valid(1'b0, "col_k2_release");
        wait_col(4'b1011, "col_wait_col2");
        held[3] = 1'b1;
        wait_col(4'b0111, "col_wait_col3");
        repeat (39) step();
        check("col_before_accept", 32'(key_valid_o), 32'd0);
        do_read(16'h8002, 16'h800A, "col_rd");
        check("col_valid", 32'(key_valid_o), 32'd1);
        held = 16'h0000;
        wait_valid(1'b0, "col_release");

        // Reset in the middle of DEBOUNCE
        wait_col(4'b1011, "mrst_wait_col2");
        held[5] = 1'b1;
        wait_col(4'b1101, "mrst_wait_col1");
        repeat (15) step();
        check("mrst_pre_d", 32'(d_o), 32'h0000_800A);
        check("mrst_pre_col", 32'(col_o), 32'h0000_000D);
        rst_i = 1'b0;
        step();
        check("mrst_d", 32'(d_o), 32'h0000_0000);
        check("mrst_col", 32'(col_o), 32'h0000_000E);
        check("mrst_valid", 32'(key_valid_o), 32'd0);
        held  = 16'h0000;
        rst_i = 1'b1;
        check_rotation_after_reset("mrst_rot");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
